sram_bus_master: RTL

Initiator end of the byte-wide SRAM bus (en/wr/addr/wr_data/rd_data). It accepts read/write commands on a valid/ready command port and buffers them in a command FIFO. It drives one bus transaction per cycle. For each read it captures rd_data after a fixed latency and returns it, tagged with its address, through a response FIFO. It replaces hand-driven stimulus and feeds the SRAM responder in the sramTb environment.

---
 rtl/sram_bus_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_master.sv
// sram_bus_master: initiator side of the byte-wide SRAM bus.
// Commands are queued in a command FIFO and issued one per clock.
// Read data is captured RD_LAT cycles after issue and queued, tagged with
// its address, in a response FIFO. Reads are admitted only while a response
// slot is guaranteed, so the response FIFO can never overflow.
module sram_bus_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              en_o,
    output logic              wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic              busy_o
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = RPW + 1;
    // wide enough for reads in flight plus stored responses
    localparam int FLW = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

    // command FIFO
    logic              cmd_wr_mem   [CMD_DEPTH];
    logic [ADDR_W-1:0] cmd_addr_mem [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
    logic [CPW-1:0]    cmd_wptr_q, cmd_wptr_d;
    logic [CPW-1:0]    cmd_rptr_q, cmd_rptr_d;
    logic [CCW-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic              cmd_push, cmd_pop;
    logic              head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // bus output registers
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // read tag pipeline: stage i holds a read issued i+1 cycles ago
    logic [RD_LAT-1:0] pipe_v_q;
    logic [ADDR_W-1:0] pipe_a_q [RD_LAT];

    // response FIFO
    logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
    logic [ADDR_W-1:0] rsp_addr_mem [RSP_DEPTH];
    logic [RPW-1:0]    rsp_wptr_q, rsp_wptr_d;
    logic [RPW-1:0]    rsp_rptr_q, rsp_rptr_d;
    logic [RCW-1:0]    rsp_cnt_q, rsp_cnt_d;
    logic              rsp_push, rsp_pop;

    logic [FLW-1:0]    in_flight;
    logic              credit_ok;

    assign head_wr   = cmd_wr_mem[cmd_rptr_q];
    assign head_addr = cmd_addr_mem[cmd_rptr_q];
    assign head_data = cmd_data_mem[cmd_rptr_q];

    assign cmd_ready_o = (cmd_cnt_q != CCW'(CMD_DEPTH));
    assign cmd_push    = cmd_valid_i && cmd_ready_o;

    // Reads on the bus or in the tag pipeline that still owe a response slot.
    always_comb begin
        in_flight = FLW'(en_q && !wr_q);
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + FLW'(pipe_v_q[i]);
        end
    end

    // A read at the head blocks everything behind it until a slot frees up.
    assign credit_ok = (in_flight + FLW'(rsp_cnt_q)) < FLW'(RSP_DEPTH);
    assign cmd_pop   = (cmd_cnt_q != '0) && (head_wr || credit_ok);

    assign rsp_push = pipe_v_q[RD_LAT-1];
    assign rsp_pop  = rsp_valid_o && rsp_ready_i;

    // Next-state for FIFO pointers/counts and the bus registers.
    always_comb begin
        cmd_wptr_d = cmd_wptr_q;
        cmd_rptr_d = cmd_rptr_q;
        cmd_cnt_d  = cmd_cnt_q;
        if (cmd_push) cmd_wptr_d = cmd_wptr_q + CPW'(1);
        if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + CPW'(1);
        if (cmd_push && !cmd_pop) cmd_cnt_d = cmd_cnt_q + CCW'(1);
        if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - CCW'(1);

        rsp_wptr_d = rsp_wptr_q;
        rsp_rptr_d = rsp_rptr_q;
        rsp_cnt_d  = rsp_cnt_q;
        if (rsp_push) rsp_wptr_d = rsp_wptr_q + RPW'(1);
        if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + RPW'(1);
        if (rsp_push && !rsp_pop) rsp_cnt_d = rsp_cnt_q + RCW'(1);
        if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - RCW'(1);

        en_d      = cmd_pop;
        wr_d      = cmd_pop && head_wr;
        addr_d    = cmd_pop ? head_addr : '0;
        wr_data_d = (cmd_pop && head_wr) ? head_data : '0;
    end

    // State registers; reset wins over every other event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            pipe_v_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_a_q[i] <= '0;
        end else begin
            cmd_wptr_q <= cmd_wptr_d;
            cmd_rptr_q <= cmd_rptr_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_wptr_q <= rsp_wptr_d;
            rsp_rptr_q <= rsp_rptr_d;
            rsp_cnt_q  <= rsp_cnt_d;
            en_q       <= en_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            pipe_v_q[0] <= en_q && !wr_q;
            pipe_a_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_a_q[i] <= pipe_a_q[i-1];
            end
        end
    end

    // FIFO storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_wr_mem[cmd_wptr_q]   <= cmd_wr_i;
            cmd_addr_mem[cmd_wptr_q] <= cmd_addr_i;
            cmd_data_mem[cmd_wptr_q] <= cmd_wdata_i;
        end
        if (rsp_push) begin
            rsp_data_mem[rsp_wptr_q] <= rd_data_i;
            rsp_addr_mem[rsp_wptr_q] <= pipe_a_q[RD_LAT-1];
        end
    end

    // The credit check must make a push into a full response FIFO impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(rsp_push && (rsp_cnt_q == RCW'(RSP_DEPTH))));
        end
    end

    assign en_o        = en_q;
    assign wr_o        = wr_q;
    assign addr_o      = addr_q;
    assign wr_data_o   = wr_data_q;
    assign rsp_valid_o = (rsp_cnt_q != '0);
    assign rsp_data_o  = rsp_data_mem[rsp_rptr_q];
    assign rsp_addr_o  = rsp_addr_mem[rsp_rptr_q];
    assign busy_o      = (cmd_cnt_q != '0) || (in_flight != '0) || en_q;

endmodule
